color_sample_packer: RTL and testbench
======================================

// Module: color_sample_packer
// PURPOSE
//   Consumer end of the color-adjust path: accepts adjusted color samples one
//   per handshake and packs samplesPerWord of them into one wide word. Packed
//   words are buffered in a small FIFO and sent downstream on a valid/ready port
//   (frame-buffer writer / DMA). in_last closes a line early, flushing a partial word.
// PARAMETERS
//   colorWidth      8  bits per color sample (matches adjustedColor width)
//   samplesPerWord  4  samples per output word, >=2
//   fifoDepth       4  output word FIFO entries, power of 2, >=2
// PORTS
//   clk         in   1                         system clock, 50 MHz
//   reset       in   1                         asynchronous, active-low reset
//   in_valid    in   1                         in_color/in_last valid
//   in_ready    out  1                         packer accepts the sample this cycle
//   in_color    in   colorWidth                adjusted color sample
//   in_last     in   1                         sample is last of line; flush word
//   out_valid   out  1                         out_* hold a packed word
//   out_ready   in   1                         downstream accepts the word
//   out_data    out  colorWidth*samplesPerWord packed samples, lane 0 in LSBs
//   out_keep    out  samplesPerWord            per-lane valid mask
//   out_last    out  1                         word ends a line
//   fifo_level  out  $clog2(fifoDepth+1)       words currently buffered
// BEHAVIOUR
// - Reset (reset==0, async): lane counter=0, accumulator=0, FIFO empty.
//   out_valid=0, out_data=0, out_keep=0, out_last=0, fifo_level=0, in_ready=0
//   while reset is held. Any partial word and buffered words are discarded.
// - Input accept: in_valid && in_ready. in_ready = !fifo_full (registered).
//   The FIFO frees one entry on out pop.
// - Packing: the accepted sample goes to lane k = lane counter, bits
//   [k*colorWidth +: colorWidth]. The lane counter increments and wraps to 0 after
//   lane samplesPerWord-1 or after an in_last sample.
// - Word close: the word closes on an accept at lane samplesPerWord-1 or on an
//   accept with in_last=1. The closed word {data, keep, last} is pushed to the
//   FIFO in the same clock edge. The accumulator then clears to 0.
//   keep = lanes 0..k set. Lanes above k in data are zero. last = in_last.
// - Latency: the word closes on the accept edge at cycle t. With the FIFO empty,
//   out_valid=1 from cycle t+1.
// - Output: out_valid = !fifo_empty. out_data/keep/last show the FIFO head and stay
//   stable while out_valid && !out_ready. Pop on out_valid && out_ready.
// - Simultaneous push and pop: fifo_level is unchanged and order is preserved.
//   When the FIFO is full and popped, in_ready rises the next cycle, never the same cycle.
// - in_last at lane 0: one-sample word, keep=...0001, last=1.
// - in_valid=0 holds the accumulator indefinitely. There is no timeout flush.
// - fifo_level counts 0..fifoDepth. Read/write pointers wrap modulo fifoDepth
//   and use an extra MSB to tell full from empty.
// STRUCTURE
// - Package color_stream_pkg holds:
//   - localparams COLOR_WIDTH_DEFAULT=8 and SAMPLES_PER_WORD_DEFAULT=4
//   - function keep_mask(lane) that returns a thermometer mask for lanes 0..lane
//   - the word record layout {last, keep, data}
// - Sub-module color_word_fifo: synchronous FIFO of width
//   colorWidth*samplesPerWord+samplesPerWord+1, depth fifoDepth. It provides
//   full/empty/level and uses the same clk/reset.
// - The top level holds only the lane counter, the accumulator and the close logic.
// TESTING (colorWidth=8, samplesPerWord=4, fifoDepth=4)
// - Send 4 samples 0x11,0x22,0x33,0x44, in_last=0, out_ready=1
//   -> one word 0x44332211, keep=1111, last=0, out_valid the cycle after the 4th accept.
// - Send 0xAA,0xBB then 0xCC with in_last=1
//   -> word 0x00CCBBAA, keep=0111, last=1; the next sample lands in lane 0.
// - Send a single 0x5A with in_last=1 -> word 0x0000005A, keep=0001, last=1.
// - out_ready=0, stream 20 samples
//   -> fifo_level reaches 4, in_ready=0 after the 16th accept, out_data stable.
//   Release out_ready -> 4 words in order, in_ready back 1 cycle after the first pop.
// - Steady stream at full rate with out_ready toggling 1/0 each cycle
//   -> no samples lost or duplicated, word order matches a reference model.
// - Assert reset mid-word after 2 samples and with 2 words buffered
//   -> out_valid=0, fifo_level=0 at once. The first post-reset sample lands in lane 0.

Source files
------------

// File: rtl/color_stream_pkg.sv
// color_stream_pkg: shared defaults, word record layout and lane keep-mask helper
package color_stream_pkg;
  localparam int COLOR_WIDTH_DEFAULT = 8;
  localparam int SAMPLES_PER_WORD_DEFAULT = 4;
  typedef struct packed {
    logic last;
    logic [SAMPLES_PER_WORD_DEFAULT-1:0] keep;
    logic [COLOR_WIDTH_DEFAULT*SAMPLES_PER_WORD_DEFAULT-1:0] data;
  } color_word_t;
  function automatic logic [31:0] keep_mask(input int unsigned lane);
    return 32'((64'd2 << lane) - 64'd1);
  endfunction
endpackage

// File: rtl/color_word_fifo.sv
// color_word_fifo: synchronous word FIFO with full/empty/level and zeroed output when empty
module color_word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    level = wr_q - rd_q;
    dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
    do_push = push && !full;
    wr_d = do_push ? wr_q + ONE : wr_q;
    rd_d = (pop && !empty) ? rd_q + ONE : rd_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/color_sample_packer.sv
// color_sample_packer: packs color samples into lane words, flushes on in_last, buffers words in a FIFO
module color_sample_packer
  import color_stream_pkg::*;
#(
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEFAULT,
  parameter int SAMPLES_PER_WORD = SAMPLES_PER_WORD_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [COLOR_WIDTH-1:0]                in_color,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [COLOR_WIDTH*SAMPLES_PER_WORD-1:0] out_data,
  output logic [SAMPLES_PER_WORD-1:0]           out_keep,
  output logic                                  out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);
  localparam int LW = $clog2(SAMPLES_PER_WORD);
  localparam int DW = COLOR_WIDTH * SAMPLES_PER_WORD;
  localparam int WW = DW + SAMPLES_PER_WORD + 1;
  logic [LW-1:0] lane_q, lane_d;
  logic [DW-1:0] acc_q, acc_d, word_data;
  logic [SAMPLES_PER_WORD-1:0] word_keep;
  logic [WW-1:0] fifo_dout;
  logic ready_q, accept, close, fifo_full, fifo_empty;
  always_comb begin
    in_ready = ready_q && !fifo_full;
    accept = in_valid && in_ready;
    close = accept && (in_last || lane_q == LW'(SAMPLES_PER_WORD - 1));
    word_data = acc_q;
    word_data[lane_q*COLOR_WIDTH +: COLOR_WIDTH] = in_color;
    word_keep = SAMPLES_PER_WORD'(keep_mask(32'(lane_q)));
    lane_d = !accept ? lane_q : close ? '0 : LW'(lane_q + 1);
    acc_d = !accept ? acc_q : close ? '0 : word_data;
    out_valid = !fifo_empty;
    {out_last, out_keep, out_data} = fifo_dout;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      acc_q <= '0;
      ready_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      acc_q <= acc_d;
      ready_q <= 1'b1;
    end
  end
  color_word_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (close),
    .din   ({in_last, word_keep, word_data}),
    .pop   (out_valid && out_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
endmodule

// File: tb/tb_color_sample_packer.sv
// tb_color_sample_packer: directed table and corner-sequence checks against a word-packing reference model
module tb_color_sample_packer;
  import color_stream_pkg::*;
  typedef struct {
    logic [7:0]  c;
    logic        l;
    logic        cl;
    logic [31:0] d;
    logic [3:0]  k;
    logic        el;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_color = 8'h00;
  logic in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  logic [2:0] fifo_level;
  int total = 0, passed = 0, n = 0;
  color_word_t expq[$];
  logic [31:0] m_data = '0;
  logic [3:0] m_keep = '0;
  int m_lane = 0;
  vec_t tbl[14];
  color_sample_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_color   (in_color),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .fifo_level (fifo_level)
  );
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic observe();
    color_word_t w;
    if (reset && out_valid && out_ready) begin
      chk("pop_pending", 64'(expq.size() > 0), 64'(1));
      if (expq.size() > 0) begin
        w = expq.pop_front();
        chk("pop_word", 64'({out_last, out_keep, out_data}), 64'(w));
      end
    end
    if (reset && in_valid && in_ready) begin
      m_data[m_lane*8 +: 8] = in_color;
      m_keep[m_lane] = 1'b1;
      if (in_last || m_lane == 3) begin
        expq.push_back('{last: in_last, keep: m_keep, data: m_data});
        m_data = '0;
        m_keep = '0;
        m_lane = 0;
      end else m_lane++;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] c, input logic l);
    in_valid = 1'b1;
    in_color = c;
    in_last = l;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic stream(input int cycles, input int limit);
    logic a;
    for (int i = 0; i < cycles; i++) begin
      in_valid = n < limit;
      in_color = 8'(8'h40 + n);
      in_last = 1'b0;
      a = in_valid && in_ready;
      tick();
      if (a) n++;
    end
    in_valid = 1'b0;
  endtask
  initial begin
    tbl = '{
      '{8'h11, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'h22, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'h33, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0},
      '{8'hAA, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'hBB, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'hCC, 1'b1, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1},
      '{8'h5A, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1},
      '{8'h01, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'h02, 1'b1, 1'b1, 32'h00000201, 4'h3, 1'b1},
      '{8'hF0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'hF1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'hF2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0},
      '{8'hF3, 1'b1, 1'b1, 32'hF3F2F1F0, 4'hF, 1'b1}
    };
    #25;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_keep", 64'(out_keep), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_color = tbl[i].c;
      in_last = tbl[i].l;
      chk("vec_in_ready", 64'(in_ready), 64'(1));
      tick();
      chk("vec_out_valid", 64'(out_valid), 64'(tbl[i].cl));
      if (tbl[i].cl) begin
        chk("vec_data", 64'(out_data), 64'(tbl[i].d));
        chk("vec_keep", 64'(out_keep), 64'(tbl[i].k));
        chk("vec_last", 64'(out_last), 64'(tbl[i].el));
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    tick();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("hold_no_word", 64'(out_valid), 64'(0));
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("hold_word", 64'({out_last, out_keep, out_data}), 64'({1'b0, 4'hF, 32'h04030201}));
    tick();
    out_ready = 1'b0;
    n = 0;
    stream(30, 20);
    chk("bp_accepts", 64'(n), 64'(16));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_level", 64'(fifo_level), 64'(4));
    chk("bp_head", 64'(out_data), 64'(32'h43424140));
    in_valid = 1'b1;
    in_color = 8'h50;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_stable", 64'(out_data), 64'(32'h43424140));
    chk("bp_level_hold", 64'(fifo_level), 64'(4));
    out_ready = 1'b1;
    chk("bp_ready_pop_cycle", 64'(in_ready), 64'(0));
    tick();
    chk("bp_ready_after_pop", 64'(in_ready), 64'(1));
    chk("bp_level_after_pop", 64'(fifo_level), 64'(3));
    stream(10, 20);
    chk("bp_all_accepted", 64'(n), 64'(20));
    for (int i = 0; i < 6; i++) tick();
    chk("bp_drained_model", 64'(expq.size()), 64'(0));
    chk("bp_drained_level", 64'(fifo_level), 64'(0));
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_color = 8'(i * 7 + 3);
      in_last = (i % 9) == 8;
      out_ready = i[0];
      tick();
    end
    out_ready = 1'b1;
    send(8'hEE, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("tg_drained_model", 64'(expq.size()), 64'(0));
    chk("tg_drained_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_color = 8'(8'h60 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("mr_level", 64'(fifo_level), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'(0));
    chk("mr_level_zero", 64'(fifo_level), 64'(0));
    chk("mr_in_ready", 64'(in_ready), 64'(0));
    chk("mr_out_data", 64'(out_data), 64'(0));
    expq.delete();
    m_data = '0;
    m_keep = '0;
    m_lane = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h77, 1'b1);
    chk("mr_lane0_word", 64'({out_last, out_keep, out_data}), 64'({1'b1, 4'h1, 32'h00000077}));
    for (int i = 0; i < 3; i++) tick();
    chk("mr_drained_model", 64'(expq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
